// File: rtl/width_convert_pkg.sv
// Shared types and helpers for the width_convert write-side arbiter.
// Holds the arbiter state encoding and the round-robin pick function.
package width_convert_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  localparam int unsigned MAX_NCH = 32;

  // First set request after ptr, wrapping modulo n; ptr itself is checked last.
  function automatic int unsigned rr_pick(
    input logic [MAX_NCH-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_NCH; i++) begin
      idx = (ptr + i) % n;
      if (i <= n && !found && req[idx[4:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Forward register slice for a valid/ready stream.
// Drain and fill in the same cycle keep one beat per cycle.
module stream_reg_slice #(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_vld,
  output logic             in_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_vld,
  input  logic             out_ready
);

  assign in_ready = ~out_vld | out_ready;

  // Load on accept, otherwise hold while stalled or clear once drained.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_ready) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_ready) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/width_convert_arbiter.sv
// Packet-granular round-robin arbiter in front of the width_convert write port.
// A grant is held from the first beat until the beat carrying last.
module width_convert_arbiter
  import width_convert_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int ISIZE = 8,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [NCH*ISIZE-1:0] s_data,
  input  logic [NCH-1:0]     s_vld,
  output logic [NCH-1:0]     s_ready,
  input  logic [NCH-1:0]     s_last,
  input  logic [NCH-1:0]     s_align_last,
  output logic [ISIZE-1:0]   m_data,
  output logic               m_vld,
  input  logic               m_ready,
  output logic               m_last,
  output logic               m_align_last,
  output logic [CW-1:0]      m_chn,
  output logic               busy
);

  localparam int PW = ISIZE + 2 + CW;

  arb_state_e       state;
  logic [CW-1:0]    gnt;
  logic [CW-1:0]    rr_ptr;
  logic             lock;
  logic             fill;
  logic             fill_ready;
  logic             accept;
  logic [ISIZE-1:0] sel_data;
  logic [PW-1:0]    in_pay;
  logic [PW-1:0]    out_pay;

  assign lock     = (state == ARB_LOCK) & ~rst;
  assign sel_data = s_data[int'(gnt)*ISIZE +: ISIZE];
  assign fill     = lock & s_vld[gnt];
  assign accept   = fill & fill_ready;
  assign in_pay   = {sel_data, s_last[gnt], s_align_last[gnt], gnt};
  assign busy     = (state == ARB_LOCK);

  assign {m_data, m_last, m_align_last, m_chn} = out_pay;

  // Only the granted channel ever sees ready.
  always_comb begin
    s_ready = '0;
    if (lock) s_ready[gnt] = fill_ready;
  end

  // Pick a winner when idle, release the grant after the last beat.
  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      rr_ptr <= CW'(NCH - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|s_vld) begin
            gnt   <= CW'(rr_pick(MAX_NCH'(s_vld), 32'(rr_ptr), NCH));
            state <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (accept && s_last[gnt]) begin
            rr_ptr <= gnt;
            state  <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  stream_reg_slice #(
    .DSIZE(PW)
  ) u_slice (
    .clock    (clock),
    .rst      (rst),
    .in_data  (in_pay),
    .in_vld   (fill),
    .in_ready (fill_ready),
    .out_data (out_pay),
    .out_vld  (m_vld),
    .out_ready(m_ready)
  );

endmodule

// File: tb/tb_width_convert_arbiter.sv
// Directed bench for width_convert_arbiter with NCH=4, ISIZE=8.
// Per-channel beat queues feed the DUT; m-side handshakes are logged.
module tb_width_convert_arbiter;

  localparam int NCH   = 4;
  localparam int ISIZE = 8;

  logic                 clock;
  logic                 rst;
  logic [NCH*ISIZE-1:0] s_data;
  logic [NCH-1:0]       s_vld;
  logic [NCH-1:0]       s_ready;
  logic [NCH-1:0]       s_last;
  logic [NCH-1:0]       s_align_last;
  logic [ISIZE-1:0]     m_data;
  logic                 m_vld;
  logic                 m_ready;
  logic                 m_last;
  logic                 m_align_last;
  logic [1:0]           m_chn;
  logic                 busy;

  width_convert_arbiter #(
    .NCH  (NCH),
    .ISIZE(ISIZE)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .s_data      (s_data),
    .s_vld       (s_vld),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .s_align_last(s_align_last),
    .m_data      (m_data),
    .m_vld       (m_vld),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .m_align_last(m_align_last),
    .m_chn       (m_chn),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       align;
  } beat_t;

  typedef struct {
    logic [1:0] chn;
    logic [7:0] data;
    logic       last;
    logic       align;
    logic       bz;
    int         cyc;
  } obs_t;

  typedef struct {
    logic       mr;
    logic       vld;
    logic [7:0] data;
    logic       sr2;
    logic       bz;
  } vec_t;

  beat_t srcq[NCH][$];
  obs_t  outq[$];
  vec_t  tbl[10];
  logic [NCH-1:0] en;

  int n_chk;
  int n_err;
  int cyc;

  logic           sn_mvld;
  logic [7:0]     sn_mdata;
  logic           sn_busy;
  logic [NCH-1:0] sn_sready;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        s_vld[i]               = 1'b1;
        s_data[i*ISIZE +: ISIZE] = srcq[i][0].data;
        s_last[i]              = srcq[i][0].last;
        s_align_last[i]        = srcq[i][0].align;
      end else begin
        s_vld[i]        = 1'b0;
        s_last[i]       = 1'b0;
        s_align_last[i] = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int c, input logic [7:0] base,
                          input int nb, input logic al);
    for (int b = 0; b < nb; b++)
      srcq[c].push_back('{base + 8'(b), b == nb - 1, al && (b == nb - 1)});
  endtask

  // One clock: sample mid-cycle, then retire accepted beats after the edge.
  task automatic tick();
    logic [NCH-1:0] acc;
    @(negedge clock);
    sn_mvld   = m_vld;
    sn_mdata  = m_data;
    sn_busy   = busy;
    sn_sready = s_ready;
    acc       = s_vld & s_ready;
    if (m_vld && m_ready)
      outq.push_back('{m_chn, m_data, m_last, m_align_last, busy, cyc});
    cyc++;
    @(posedge clock);
    #1;
    for (int i = 0; i < NCH; i++)
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  initial begin
    logic [1:0] exp_chn2[5];
    logic [1:0] exp_chn4[8];
    logic [7:0] exp_dat4[8];
    int         exp_gap;

    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    en    = '1;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'hC0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'hC1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'hC2, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    exp_chn2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_chn4 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
    exp_dat4 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hD0, 8'hD1, 8'hA0, 8'hA1};

    // Test 1: reset with every channel requesting
    rst          = 1'b1;
    s_vld        = '1;
    s_data       = '0;
    s_last       = '0;
    s_align_last = '0;
    m_ready      = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t1_rst_s_ready", 32'(s_ready), 32'h0);
      chk("t1_rst_m_vld", 32'(m_vld), 32'h0);
      chk("t1_rst_busy", 32'(busy), 32'h0);
      @(posedge clock);
      #1;
    end
    rst = 1'b0;
    @(negedge clock);
    chk("t1_post_s_ready", 32'(s_ready), 32'h0);
    chk("t1_post_m_vld", 32'(m_vld), 32'h0);
    chk("t1_post_busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;

    // Test 2: 3-beat packets on all channels, ch0 twice
    for (int c = 0; c < NCH; c++) load_pkt(c, 8'hA0 + 8'(c * 16), 3, 1'b0);
    load_pkt(0, 8'hA0, 3, 1'b0);
    outq.delete();
    drive();
    for (int n = 0; n < 100 && outq.size() < 15; n++) tick();
    chk("t2_beat_count", outq.size(), 15);
    for (int j = 0; j < outq.size() && j < 15; j++) begin
      chk("t2_chn", 32'(outq[j].chn), 32'(exp_chn2[j / 3]));
      chk("t2_data", 32'(outq[j].data),
          32'(8'hA0 + 8'(exp_chn2[j / 3]) * 8'd16 + 8'(j % 3)));
      chk("t2_last", 32'(outq[j].last), 32'((j % 3) == 2));
      if (j > 0) begin
        exp_gap = (j % 3 == 0) ? 2 : 1;
        chk("t2_spacing", outq[j].cyc - outq[j-1].cyc, exp_gap);
      end
    end

    // Test 3: ch2 4 beats under m_ready 1,0,0,1 pattern
    outq.delete();
    load_pkt(2, 8'hC0, 4, 1'b0);
    drive();
    for (int i = 0; i < 10; i++) begin
      m_ready = tbl[i].mr;
      tick();
      chk("t3_m_vld", 32'(sn_mvld), 32'(tbl[i].vld));
      if (tbl[i].vld) chk("t3_m_data", 32'(sn_mdata), 32'(tbl[i].data));
      chk("t3_s_ready2", 32'(sn_sready[2]), 32'(tbl[i].sr2));
      chk("t3_busy", 32'(sn_busy), 32'(tbl[i].bz));
    end
    chk("t3_beat_count", outq.size(), 4);
    for (int j = 0; j < outq.size() && j < 4; j++)
      chk("t3_out_data", 32'(outq[j].data), 32'(8'hC0 + 8'(j)));

    // Test 4: ch1 stalls mid-packet while ch0 and ch3 wait
    m_ready = 1'b1;
    outq.delete();
    load_pkt(1, 8'hB0, 4, 1'b0);
    drive();
    repeat (3) tick();
    en[1] = 1'b0;
    load_pkt(0, 8'hA0, 2, 1'b0);
    load_pkt(3, 8'hD0, 2, 1'b0);
    drive();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_busy", 32'(sn_busy), 32'h1);
      chk("t4_hold_others", 32'(sn_sready & 4'b1101), 32'h0);
    end
    en[1] = 1'b1;
    drive();
    for (int n = 0; n < 60 && outq.size() < 8; n++) tick();
    chk("t4_beat_count", outq.size(), 8);
    for (int j = 0; j < outq.size() && j < 8; j++) begin
      chk("t4_chn", 32'(outq[j].chn), 32'(exp_chn4[j]));
      chk("t4_data", 32'(outq[j].data), 32'(exp_dat4[j]));
    end

    // Test 5: single-beat packet on ch3
    outq.delete();
    srcq[3].push_back('{8'h5C, 1'b1, 1'b1});
    drive();
    for (int n = 0; n < 20 && outq.size() < 1; n++) tick();
    chk("t5_beat_count", outq.size(), 1);
    if (outq.size() > 0) begin
      chk("t5_chn", 32'(outq[0].chn), 32'h3);
      chk("t5_data", 32'(outq[0].data), 32'h5C);
      chk("t5_last", 32'(outq[0].last), 32'h1);
      chk("t5_align", 32'(outq[0].align), 32'h1);
      chk("t5_idle", 32'(outq[0].bz), 32'h0);
    end

    // Test 6: reset while a beat is stalled in the slice
    outq.delete();
    m_ready = 1'b0;
    load_pkt(2, 8'hC0, 3, 1'b0);
    drive();
    repeat (3) tick();
    chk("t6_pre_m_vld", 32'(sn_mvld), 32'h1);
    chk("t6_pre_busy", 32'(sn_busy), 32'h1);
    rst = 1'b1;
    load_pkt(1, 8'hB0, 2, 1'b0);
    load_pkt(3, 8'hD0, 2, 1'b0);
    drive();
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("t6_post_m_vld", 32'(sn_mvld), 32'h0);
    chk("t6_post_busy", 32'(sn_busy), 32'h0);
    chk("t6_post_s_ready", 32'(sn_sready), 32'h0);
    for (int n = 0; n < 20 && outq.size() < 1; n++) tick();
    chk("t6_beat_count", 32'(outq.size() >= 1), 32'h1);
    if (outq.size() > 0) begin
      chk("t6_first_chn", 32'(outq[0].chn), 32'h1);
      chk("t6_first_data", 32'(outq[0].data), 32'hB0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
